// File: rtl/regfile_bus_master.sv
// rtl/regfile_bus_master.sv - APB-style initiator driving the matrix-multiplier register file
// One command per handshake, one SETUP+ACCESS transfer, response with error/timeout status.
module regfile_bus_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int BUS_WIDTH      = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int MAX_DIM       = BUS_WIDTH / DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
  input  logic [MAX_DIM-1:0]    cmd_strb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [MAX_DIM-1:0]    pstrb_o,
  input  logic                  pready_i,
  input  logic [BUS_WIDTH-1:0]  prdata_i,
  input  logic                  pslverr_i,
  output logic                  busy_o
);

  localparam int ALIGN = $clog2(BUS_WIDTH / 8);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             misaligned;
  logic             timeout_hit;

  assign accept     = cmd_valid_i & cmd_ready_o;
  assign misaligned = |cmd_addr_i[ALIGN-1:0];
  // cnt counts completed wait cycles, so the last allowed ACCESS cycle sees TIMEOUT_CYCLES-1.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !pready_i && (cnt == CNT_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = misaligned ? RESP : SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (pready_i || timeout_hit) state_next = RESP;
      RESP:    if (rsp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cmd_ready_o   <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      pwrite_o      <= 1'b0;
      paddr_o       <= '0;
      pwdata_o      <= '0;
      pstrb_o       <= '0;
      busy_o        <= 1'b0;
      cnt           <= '0;
    end else begin
      busy_o <= (state_next != IDLE);
      case (state)
        IDLE: begin
          cmd_ready_o <= !accept;
          if (accept) begin
            if (misaligned) begin
              rsp_valid_o   <= 1'b1;
              rsp_err_o     <= 1'b1;
              rsp_timeout_o <= 1'b0;
              rsp_rdata_o   <= '0;
            end else begin
              psel_o    <= 1'b1;
              penable_o <= 1'b0;
              pwrite_o  <= cmd_write_i;
              paddr_o   <= cmd_addr_i;
              pwdata_o  <= cmd_wdata_i;
              pstrb_o   <= cmd_write_i ? cmd_strb_i : '0;
              cnt       <= '0;
            end
          end
        end
        SETUP: penable_o <= 1'b1;
        ACCESS: begin
          if (pready_i) begin
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_rdata_o   <= (pwrite_o || pslverr_i) ? '0 : prdata_i;
            rsp_err_o     <= pslverr_i;
            rsp_timeout_o <= 1'b0;
          end else if (timeout_hit) begin
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            cmd_ready_o   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_bus_master.sv
// tb/tb_regfile_bus_master.sv - randomized bench for regfile_bus_master against a rule-level model
// Expected response, latency and bus-cycle counts come from the transfer rules, not the RTL structure.
module tb_regfile_bus_master;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [63:0] cmd_wdata = '0;
  logic [1:0]  cmd_strb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel, penable, pwrite;
  logic [31:0] paddr;
  logic [63:0] pwdata;
  logic [1:0]  pstrb;
  logic        pready = 1'b0;
  logic [63:0] prdata = '0;
  logic        pslverr = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_bus_master #(
    .DATA_WIDTH(32), .BUS_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
    .pwdata_o(pwdata), .pstrb_o(pstrb), .pready_i(pready), .prdata_i(prdata),
    .pslverr_i(pslverr), .busy_o(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cmd_ready();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
  endtask

  // Full command/bus/response exchange; the slave raises pready after 'waits' low ACCESS cycles.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [63:0] wd,
                         input logic [1:0] strb, input int waits, input logic serr,
                         input logic [63:0] rd, input int hold);
    logic        mis, exp_to, exp_err;
    logic [63:0] exp_rd;
    int          exp_acc, cycles, acc, psel_cycles;
    logic        got;
    logic [63:0] s_rd;
    logic        s_err, s_to;

    mis     = (addr % 8) != 0;
    exp_to  = !mis && (waits >= TO);
    exp_acc = mis ? 0 : (exp_to ? TO : waits + 1);
    exp_err = mis || exp_to || serr;
    exp_rd  = (exp_err || wr) ? 64'd0 : rd;

    wait_cmd_ready();
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = strb;
    @(posedge clk);
    #1 cmd_valid = 1'b0;

    cycles = 0; acc = 0; psel_cycles = 0; got = 1'b0;
    while (!got && cycles < 30) begin
      @(negedge clk);
      cycles++;
      if (rsp_valid) begin
        got = 1'b1;
        pready = 1'b0;
      end else begin
        if (psel) begin
          psel_cycles++;
          check("paddr", paddr, addr);
          check("pwrite", pwrite, wr);
          check("pstrb", pstrb, wr ? strb : 2'b00);
          if (wr) check("pwdata", pwdata, wd);
        end
        if (psel && penable) begin
          acc++;
          pready  = (acc > waits);
          prdata  = pready ? rd : {$urandom, $urandom};
          pslverr = pready ? serr : 1'($urandom);
        end else begin
          pready  = 1'b0;
          pslverr = 1'($urandom);
        end
      end
    end
    check("rsp_seen", got, 1'b1);
    check("latency", cycles, mis ? 1 : exp_acc + 2);
    check("access_cycles", acc, exp_acc);
    check("psel_cycles", psel_cycles, mis ? 0 : exp_acc + 1);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_timeout", rsp_timeout, exp_to);
    check("psel_after", {psel, penable}, 2'b00);
    check("busy_resp", busy, 1'b1);

    s_rd = rsp_rdata; s_err = rsp_err; s_to = rsp_timeout;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_rdata", rsp_rdata, s_rd);
      check("hold_flags", {rsp_err, rsp_timeout}, {s_err, s_to});
      check("hold_cmd_ready", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("consumed_valid", rsp_valid, 1'b0);
    check("consumed_cmd_ready", cmd_ready, 1'b1);
    check("consumed_busy", busy, 1'b0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_outputs", {cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite, busy}, 8'h00);
    check("reset_bus", {paddr, pstrb, rsp_rdata}, '0);
    rst_ni = 1'b1;

    run_txn(1'b1, 32'h08, 64'h0000_0000_0000_1234, 2'b11, 0, 1'b0, 64'h0, 0);
    run_txn(1'b0, 32'h10, 64'h0, 2'b11, 3, 1'b0, 64'h0000_0000_DEAD_BEEF, 0);
    run_txn(1'b0, 32'h03, 64'h0, 2'b00, 0, 1'b0, 64'h0, 1);
    run_txn(1'b1, 32'h04, 64'h55, 2'b01, 0, 1'b0, 64'h0, 0);
    run_txn(1'b0, 32'h18, 64'h0, 2'b00, 100, 1'b0, 64'h1111, 0);
    run_txn(1'b1, 32'h20, 64'hABCD, 2'b10, 0, 1'b1, 64'h0, 5);
    run_txn(1'b0, 32'h28, 64'h0, 2'b00, 1, 1'b1, 64'h2222, 2);

    wait_cmd_ready();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    while (!(psel && penable) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("mid_reset_in_access", {psel, penable}, 2'b11);
    rst_ni = 1'b0;
    @(negedge clk);
    check("mid_reset_cleared", {psel, penable, rsp_valid, cmd_ready}, 4'b0000);
    rst_ni = 1'b1;
    run_txn(1'b0, 32'h38, 64'h0, 2'b00, 2, 1'b0, 64'hCAFE_F00D_1234_5678, 0);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      a = $urandom & 32'h0000_FFF8;
      if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 7));
      run_txn(1'($urandom), a, {$urandom, $urandom}, 2'($urandom), $urandom_range(0, 6),
              ($urandom_range(0, 3) == 0), {$urandom, $urandom}, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
